// File: rtl/usb_token_arbiter_if.sv
// ----------------------------------------------------------------------------
// usb_token_arbiter_if
// Purpose : Bundles the SOF request, transfer request and token generator
//           handshakes of the USB token arbiter.
// Modports: master - arbiter side (drives sof_ready/sof_done, xfer_gnt/done,
//                    tok_* fields, tok_start, tok_err)
//           slave  - environment side (SOF generator, requesters, token
//                    generator)
// ----------------------------------------------------------------------------
interface usb_token_arbiter_if;
    // SOF generator handshake
    logic        sof_start;
    logic [10:0] sof_frame;
    logic        sof_ready;
    logic        sof_done;
    // Transfer requesters (two, packed per requester)
    logic [1:0]  xfer_req;
    logic [3:0]  xfer_type;
    logic [13:0] xfer_addr;
    logic [7:0]  xfer_endp;
    logic [1:0]  xfer_gnt;
    logic [1:0]  xfer_done;
    // Token generator handshake
    logic        tok_start;
    logic [1:0]  tok_type;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [10:0] tok_frame;
    logic        tok_ready;
    logic        tok_done;
    logic        tok_err;

    modport master (
        input  sof_start, sof_frame, xfer_req, xfer_type, xfer_addr, xfer_endp,
               tok_ready, tok_done,
        output sof_ready, sof_done, xfer_gnt, xfer_done, tok_start, tok_type,
               tok_addr, tok_endp, tok_frame, tok_err
    );

    modport slave (
        output sof_start, sof_frame, xfer_req, xfer_type, xfer_addr, xfer_endp,
               tok_ready, tok_done,
        input  sof_ready, sof_done, xfer_gnt, xfer_done, tok_start, tok_type,
               tok_addr, tok_endp, tok_frame, tok_err
    );
endinterface

// File: rtl/usb_token_arbiter.sv
// ----------------------------------------------------------------------------
// usb_token_arbiter
// Purpose : Arbitrates a single USB token generator between the SOF generator
//           (highest priority) and two round-robin transfer requesters, with
//           an end-of-frame guard window and a done timeout.
// Ports   : clk, rst_n (sync, active-low), enable, speed (01 FS, 10 HS,
//           others FS), bus (usb_token_arbiter_if.master), owner
//           (00 none, 01 SOF, 10 req0, 11 req1), frame_timer, eof_block.
// ----------------------------------------------------------------------------
module usb_token_arbiter #(
    parameter logic [15:0] FS_GUARD     = 16'd3000,
    parameter logic [15:0] HS_GUARD     = 16'd600,
    parameter logic [15:0] DONE_TIMEOUT = 16'd4095
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 speed,
    usb_token_arbiter_if.master        bus,
    output logic [1:0]                 owner,
    output logic [15:0]                frame_timer,
    output logic                       eof_block
);

    localparam logic [15:0] FsLimit = 16'd60000 - FS_GUARD;
    localparam logic [15:0] HsLimit = 16'd7500 - HS_GUARD;

    localparam logic [1:0] OwnNone = 2'b00;
    localparam logic [1:0] OwnSof  = 2'b01;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e      state_q, state_d;
    logic        sof_pend_q, sof_pend_d;
    logic [10:0] sof_frame_q, sof_frame_d;
    logic        rr_q, rr_d;           // requester index holding priority
    logic [1:0]  owner_q, owner_d;
    logic [15:0] frame_timer_q, frame_timer_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tok_start_q, tok_start_d;
    logic [1:0]  tok_type_q, tok_type_d;
    logic [6:0]  tok_addr_q, tok_addr_d;
    logic [3:0]  tok_endp_q, tok_endp_d;
    logic [10:0] tok_frame_q, tok_frame_d;
    logic        sof_done_q, sof_done_d;
    logic [1:0]  xfer_gnt_q, xfer_gnt_d;
    logic [1:0]  xfer_done_q, xfer_done_d;
    logic        tok_err_q, tok_err_d;
    logic        win;

    // Speed codes other than HS fall back to the FS window.
    assign eof_block = (speed == 2'b10) ? (frame_timer_q >= HsLimit)
                                        : (frame_timer_q >= FsLimit);

    // A lone requester wins outright; the pointer only breaks ties.
    assign win = (&bus.xfer_req) ? rr_q : bus.xfer_req[1];

    always_comb begin
        state_d       = state_q;
        sof_pend_d    = sof_pend_q;
        sof_frame_d   = sof_frame_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        tok_type_d    = tok_type_q;
        tok_addr_d    = tok_addr_q;
        tok_endp_d    = tok_endp_q;
        tok_frame_d   = tok_frame_q;
        tok_start_d   = 1'b0;
        sof_done_d    = 1'b0;
        xfer_gnt_d    = 2'b00;
        xfer_done_d   = 2'b00;
        tok_err_d     = 1'b0;
        frame_timer_d = (frame_timer_q == 16'hFFFF) ? frame_timer_q : frame_timer_q + 16'd1;

        if (bus.sof_start && !sof_pend_q) begin
            sof_pend_d  = 1'b1;
            sof_frame_d = bus.sof_frame;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Only the registered pending flag is considered here.
                if (sof_pend_q) begin
                    owner_d     = OwnSof;
                    tok_type_d  = 2'b10;
                    tok_addr_d  = '0;
                    tok_endp_d  = '0;
                    tok_frame_d = sof_frame_q;
                    state_d     = StIssue;
                end else if (!eof_block && (|bus.xfer_req)) begin
                    owner_d     = {1'b1, win};
                    tok_type_d  = win ? bus.xfer_type[3:2]  : bus.xfer_type[1:0];
                    tok_addr_d  = win ? bus.xfer_addr[13:7] : bus.xfer_addr[6:0];
                    tok_endp_d  = win ? bus.xfer_endp[7:4]  : bus.xfer_endp[3:0];
                    tok_frame_d = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (bus.tok_ready) begin
                    tok_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StWaitDone;
                    if (owner_q == OwnSof) begin
                        frame_timer_d = '0;
                    end else begin
                        xfer_gnt_d[owner_q[0]] = 1'b1;
                        rr_d                   = ~owner_q[0];
                    end
                end
            end
            StWaitDone: begin
                if (bus.tok_done) begin
                    if (owner_q == OwnSof) begin
                        sof_done_d = 1'b1;
                        sof_pend_d = 1'b0;
                    end else begin
                        xfer_done_d[owner_q[0]] = 1'b1;
                    end
                    owner_d = OwnNone;
                    state_d = StIdle;
                end else if (cnt_q == DONE_TIMEOUT - 16'd1) begin
                    // Timeout after DONE_TIMEOUT waiting cycles; no done pulse.
                    tok_err_d = 1'b1;
                    if (owner_q == OwnSof) begin
                        sof_pend_d = 1'b0;
                    end
                    owner_d = OwnNone;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase

        // Disable abandons any token silently and freezes the frame timer.
        if (!enable) begin
            state_d       = StIdle;
            owner_d       = OwnNone;
            sof_pend_d    = 1'b0;
            frame_timer_d = '0;
            cnt_d         = '0;
            tok_start_d   = 1'b0;
            sof_done_d    = 1'b0;
            xfer_gnt_d    = 2'b00;
            xfer_done_d   = 2'b00;
            tok_err_d     = 1'b0;
            rr_d          = rr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sof_pend_q    <= 1'b0;
            sof_frame_q   <= '0;
            rr_q          <= 1'b0;
            owner_q       <= OwnNone;
            frame_timer_q <= '0;
            cnt_q         <= '0;
            tok_start_q   <= 1'b0;
            tok_type_q    <= '0;
            tok_addr_q    <= '0;
            tok_endp_q    <= '0;
            tok_frame_q   <= '0;
            sof_done_q    <= 1'b0;
            xfer_gnt_q    <= 2'b00;
            xfer_done_q   <= 2'b00;
            tok_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sof_pend_q    <= sof_pend_d;
            sof_frame_q   <= sof_frame_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            frame_timer_q <= frame_timer_d;
            cnt_q         <= cnt_d;
            tok_start_q   <= tok_start_d;
            tok_type_q    <= tok_type_d;
            tok_addr_q    <= tok_addr_d;
            tok_endp_q    <= tok_endp_d;
            tok_frame_q   <= tok_frame_d;
            sof_done_q    <= sof_done_d;
            xfer_gnt_q    <= xfer_gnt_d;
            xfer_done_q   <= xfer_done_d;
            tok_err_q     <= tok_err_d;
        end
    end

    assign bus.sof_ready = ~sof_pend_q;
    assign bus.sof_done  = sof_done_q;
    assign bus.xfer_gnt  = xfer_gnt_q;
    assign bus.xfer_done = xfer_done_q;
    assign bus.tok_start = tok_start_q;
    assign bus.tok_type  = tok_type_q;
    assign bus.tok_addr  = tok_addr_q;
    assign bus.tok_endp  = tok_endp_q;
    assign bus.tok_frame = tok_frame_q;
    assign bus.tok_err   = tok_err_q;
    assign owner         = owner_q;
    assign frame_timer   = frame_timer_q;

endmodule

// File: doc/usb_token_arbiter.md
USB_TOKEN_ARBITER -- requirements
Module: usb_token_arbiter

Interface
REQ-001 SHALL have parameter FS_GUARD, default 16'd3000, meaning end-of-frame guard cycles at Full-Speed.
REQ-002 SHALL have parameter HS_GUARD, default 16'd600, meaning end-of-frame guard cycles at High-Speed.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 16'd4095, meaning maximum cycles waiting for tok_done.
REQ-004 SHALL have ports as follows; one clock; reset is synchronous and active-low:
  clk  in  1  system clock, 60 MHz
  rst_n  in  1  synchronous active-low reset
  enable  in  1  arbitration enable
  speed  in  2  01=FS, 10=HS; any other value treated as FS
  sof_start  in  1  SOF request pulse from SOF generator
  sof_frame  in  11  frame number accompanying sof_start
  sof_ready  out  1  arbiter can accept sof_start
  sof_done  out  1  one-cycle pulse, SOF token completed
  xfer_req  in  2  per-requester level request, held until its xfer_done or tok_err
  xfer_type  in  4  2 bits per requester, token type
  xfer_addr  in  14  7 bits per requester, device address
  xfer_endp  in  8  4 bits per requester, endpoint
  xfer_gnt  out  2  one-cycle pulse on the winning bit when its token is started
  xfer_done  out  2  one-cycle pulse on the owning bit when its token completes
  tok_start  out  1  one-cycle start pulse to token generator
  tok_type, tok_addr, tok_endp, tok_frame  out  2/7/4/11  token fields, stable from tok_start to tok_done
  tok_ready  in  1  token generator idle
  tok_done  in  1  token generator finished
  tok_err  out  1  one-cycle pulse on DONE_TIMEOUT expiry
  owner  out  2  00 none, 01 SOF, 10 requester 0, 11 requester 1
  frame_timer  out  16  cycles since last SOF tok_start, saturating
  eof_block  out  1  transfer grants inhibited

Function
REQ-005 SHALL latch sof_start/sof_frame into a single-entry SOF pending register; sof_ready SHALL equal NOT pending; sof_start while pending SHALL be ignored.
REQ-006 SHALL implement states IDLE, ISSUE, WAIT_DONE.
REQ-007 IDLE: if SOF pending, SHALL select SOF; else if NOT eof_block and any xfer_req bit set, SHALL select a requester round-robin; selection latches tok_* fields and owner and enters ISSUE.
REQ-008 Arbitration in IDLE SHALL use the registered pending flag only; a sof_start arriving in the same cycle is served at the next selection.
REQ-009 Round-robin: after requester i is granted, requester 1-i SHALL have priority; after reset requester 0 has priority; a lone requester SHALL win regardless of pointer.
REQ-010 SOF selection SHALL drive tok_type=2'b10, tok_frame=latched sof_frame, tok_addr=0, tok_endp=0; transfer selection SHALL drive tok_frame=0 and the requester's type/addr/endp slices.
REQ-011 ISSUE: when tok_ready=1, SHALL pulse tok_start for one cycle (plus xfer_gnt bit for transfers) and enter WAIT_DONE; otherwise SHALL remain in ISSUE.
REQ-012 WAIT_DONE: on tok_done SHALL pulse sof_done (clearing SOF pending) or the owner's xfer_done bit next cycle, set owner=00, and return to IDLE.
REQ-013 WAIT_DONE SHALL count cycles; on reaching DONE_TIMEOUT without tok_done SHALL pulse tok_err, clear SOF pending if owner=01, set owner=00, return to IDLE, and issue no done pulse.
REQ-014 frame_timer SHALL load 0 in the cycle SOF tok_start is issued, otherwise increment by 1, saturating at 16'hFFFF.
REQ-015 eof_block SHALL be 1 when frame_timer >= (60000-FS_GUARD) at FS or (7500-HS_GUARD) at HS, evaluated combinationally from registered frame_timer and speed.
REQ-016 eof_block SHALL NOT inhibit SOF selection or a transfer already past IDLE.
REQ-017 enable=0 SHALL force state IDLE, owner=00, clear SOF pending, hold frame_timer at 0, and suppress all pulses; an in-flight token is abandoned without done or error pulses.
REQ-018 sof_done, xfer_done, xfer_gnt, tok_start and tok_err SHALL never be asserted for more than one consecutive cycle per token.

Reset
REQ-019 rst_n=0 at a clk edge SHALL set state IDLE, SOF pending 0, round-robin pointer to requester 0, owner=00, frame_timer=0, DONE timeout counter 0, and tok_start, tok_type, tok_addr, tok_endp, tok_frame, sof_done, xfer_gnt, xfer_done, tok_err all 0.
REQ-020 Reset asserted mid-token SHALL take effect at the next edge without producing done or error pulses.

Verification
REQ-021 xfer_req=2'b11 held, tok_ready=1, tok_done 5 cycles after each tok_start -> xfer_gnt sequence 01,10,01,10; owner alternates 10/11.
REQ-022 sof_start (frame 0x123) same cycle as xfer_req[0] rises in IDLE -> requester 0 token first; SOF issued next with tok_type=2'b10, tok_frame=0x123; frame_timer reloads 0.
REQ-023 speed=01, frame_timer reaches 57000, xfer_req=2'b01 -> eof_block=1, no grant until next SOF issues; then requester 0 granted.
REQ-024 SOF selected, tok_ready=0 for 10 cycles -> tok_start held off; single tok_start in first cycle after tok_ready=1.
REQ-025 transfer issued, tok_done never asserted -> tok_err pulse after DONE_TIMEOUT cycles, no xfer_done, return to IDLE.
REQ-026 enable dropped in WAIT_DONE with SOF pending -> owner=00, sof_ready=1, frame_timer=0, no sof_done.
